prog_launcher: RTL
==================

# prog_launcher

Host-side initiator for the processor's Start/Ack handshake. It sequences up to NUM_PROGS program runs back to back on one TopLevel instance: it drives Start, waits for Ack, and measures each run's cycle count. A watchdog aborts a run whose Ack never arrives. It sits beside TopLevel in the hardware test harness and replaces hand-written Start/Ack bench code with synthesizable control.

## Interface
- NUM_PROGS, 3: number of programs run per Go; must be 1..16.
- START_LEN, 2: cycles Start is held high per launch; must be ≥1.
- TIMEOUT, 4096: maximum RUN cycles before abort; must be ≤ 2^CNT_W−1.
- CNT_W, 16: width of the per-run cycle counter.
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; clock Clk.
- Go  in  1  level-sampled request to run the full sequence.
- Ack  in  1  done flag from TopLevel.
- Start  out  1  registered start strobe to TopLevel.
- Busy  out  1  high in LAUNCH, RUN and RECORD.
- Done  out  1  high in DONE.
- TimedOut  out  1  sticky abort flag; cleared by the next accepted Go or by Reset.
- ProgIdx  out  4  index of the current or just-finished program.
- CountValid  out  1  one-cycle pulse when CycleCount is valid.
- CycleCount  out  CNT_W  cycles measured for program ProgIdx.
- TotalCycles  out  CNT_W+4  sum of all recorded CycleCount values for this sequence.

## Operation
- States:
  - IDLE: waits for Go.
  - LAUNCH: drives Start.
  - RUN: counts cycles and watches Ack.
  - RECORD: publishes the result.
  - DONE: sequence finished.
- Reset values: the FSM goes to IDLE. Start, Busy, Done, TimedOut, CountValid = 0. ProgIdx, CycleCount, TotalCycles = 0.
- IDLE, Go=1: load launch counter = START_LEN, clear ProgIdx, TotalCycles and TimedOut, go to LAUNCH.
- LAUNCH: Start=1. Decrement the launch counter each cycle. When the counter reaches 1, clear the run counter and go to RUN. Ack is ignored in LAUNCH.
- RUN: Start=0. The run counter increments every cycle; its value in the first RUN cycle is 1.
  - Ack=1 in a RUN cycle with count c: latch CycleCount=c and go to RECORD.
  - Else, count == TIMEOUT: latch CycleCount=TIMEOUT, set TimedOut and go to DONE. No CountValid pulse is issued and TotalCycles is not updated.
  - Ack has priority over timeout when both occur in the same cycle.
- RECORD: CountValid=1 for exactly one cycle, and TotalCycles += CycleCount.
  - ProgIdx == NUM_PROGS−1: go to DONE.
  - Otherwise: ProgIdx += 1, reload the launch counter and go to LAUNCH.
- DONE: Done=1 and all results are held stable.
  - Go=1: restart exactly as from IDLE.
  - Go=0: stay in DONE.
- Go is ignored while Busy=1.
- Arithmetic:
  - The run counter never wraps, because TIMEOUT bounds it.
  - TotalCycles is sized so that 16 runs of at most 2^CNT_W−1 cycles cannot overflow.
  - ProgIdx never exceeds NUM_PROGS−1.

## Timing
- Go sampled high at edge k (in IDLE or DONE): Start and Busy are high from edge k+1 through edge k+START_LEN.
- First RUN cycle begins at edge k+START_LEN+1 with Start=0.
- Ack sampled high in the RUN cycle whose count is c: CountValid=1 and CycleCount=c in the next cycle.
- Between programs: Start rises again on the edge after the RECORD cycle. The gap from the Ack sample to the next Start is 2 edges.
- Timeout: TimedOut and Done rise on the edge after the count reaches TIMEOUT. Busy falls on that same edge.
- Reset asserted mid-operation: at the next edge all outputs return to their reset values, Start is low, and no CountValid is emitted.
- Ack already high when a launch begins (DUT still parked at its halt): ignored during LAUNCH. If Ack is still high in the first RUN cycle, it records CycleCount=1. This matches the DUT behaviour of holding Ack until Start re-enables its PC.

## Test plan
- Ack model rises 10 cycles into RUN, START_LEN=2, NUM_PROGS=3 -> three CountValid pulses, each with CycleCount=10. ProgIdx reads 0, 1, 2. TotalCycles=30, then Done=1 and TimedOut=0.
- Ack never rises, TIMEOUT=20 -> Done=1 and TimedOut=1 on the edge after count 20. CycleCount=20, ProgIdx=0, no CountValid, TotalCycles=0.
- Ack held high continuously -> each run records CycleCount=1. Start pulses are exactly 2 cycles wide, with a 2-edge gap from Ack sample to next Start. TotalCycles=3.
- Reset asserted in the 5th RUN cycle of program 1 -> next edge: Start=0, Busy=0, ProgIdx=0, TotalCycles=0. The FSM is in IDLE and does not launch until Go.
- Go pulsed while Busy, then Go in DONE -> the mid-run Go has no effect. The Go in DONE clears TimedOut and TotalCycles and restarts at ProgIdx=0.
- Ack and timeout in the same cycle (Ack at count TIMEOUT) -> RECORD taken: CountValid=1, CycleCount=TIMEOUT, TimedOut=0.

Source files
------------

// File: rtl/prog_launcher.sv
// Host-side Start/Ack sequencer: launches NUM_PROGS back-to-back runs on TopLevel,
// times each run, and aborts a run whose Ack never arrives.
module prog_launcher #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned START_LEN = 2,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             Ack,
    output logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic             TimedOut,
    output logic [3:0]       ProgIdx,
    output logic             CountValid,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W+3:0] TotalCycles
);
    localparam int unsigned LaunchW = $clog2(START_LEN + 1);
    localparam logic [LaunchW-1:0] LaunchLoad = LaunchW'(START_LEN);
    localparam logic [CNT_W-1:0] RunLimit = CNT_W'(TIMEOUT);
    localparam logic [3:0] LastIdx = 4'(NUM_PROGS - 1);

    typedef enum logic [2:0] {StIdle, StLaunch, StRun, StRecord, StDone} state_e;

    state_e             state;
    logic [LaunchW-1:0] launchCnt;
    logic [CNT_W-1:0]   runCnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            launchCnt   <= '0;
            runCnt      <= '0;
            Start       <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            TimedOut    <= 1'b0;
            ProgIdx     <= '0;
            CountValid  <= 1'b0;
            CycleCount  <= '0;
            TotalCycles <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (Go) begin
                        state       <= StLaunch;
                        launchCnt   <= LaunchLoad;
                        ProgIdx     <= '0;
                        TotalCycles <= '0;
                        TimedOut    <= 1'b0;
                        Done        <= 1'b0;
                        Busy        <= 1'b1;
                        Start       <= 1'b1;
                    end
                end
                StLaunch: begin
                    // Ack is deliberately ignored: TopLevel may still be parked at its halt.
                    if (launchCnt == LaunchW'(1)) begin
                        state  <= StRun;
                        Start  <= 1'b0;
                        runCnt <= CNT_W'(1);
                    end else begin
                        launchCnt <= launchCnt - LaunchW'(1);
                    end
                end
                StRun: begin
                    if (Ack) begin
                        state      <= StRecord;
                        CycleCount <= runCnt;
                        CountValid <= 1'b1;
                    end else if (runCnt == RunLimit) begin
                        state      <= StDone;
                        CycleCount <= RunLimit;
                        TimedOut   <= 1'b1;
                        Done       <= 1'b1;
                        Busy       <= 1'b0;
                    end else begin
                        runCnt <= runCnt + CNT_W'(1);
                    end
                end
                StRecord: begin
                    CountValid  <= 1'b0;
                    TotalCycles <= TotalCycles + {4'b0000, CycleCount};
                    if (ProgIdx == LastIdx) begin
                        state <= StDone;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        state     <= StLaunch;
                        ProgIdx   <= ProgIdx + 4'd1;
                        launchCnt <= LaunchLoad;
                        Start     <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
